// File: rtl/reg_dump_reader.sv
// Debug readout engine: walks a register range through the shared read port
// and streams each value out over valid/ready, accumulating an additive checksum.
module reg_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] idx_r, idx_s;
  logic [ADDR_W-1:0] last_r, last_s;
  logic [ADDR_W-1:0] out_index_r, out_index_s;
  logic [DATA_W-1:0] out_data_r, out_data_s;
  logic [DATA_W-1:0] checksum_r, checksum_s;
  logic              out_valid_r, out_valid_s;
  logic              out_last_r, out_last_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              load_beat_s;
  logic              fire_s;

  assign fire_s = out_valid_r & out_ready;

  // Next-state and next-output computation; abort overrides everything but IDLE.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    last_s      = last_r;
    out_index_s = out_index_r;
    out_data_s  = out_data_r;
    out_last_s  = out_last_r;
    out_valid_s = out_valid_r;
    checksum_s  = checksum_r;
    load_beat_s = 1'b0;

    if (abort && (state_r != IDLE)) begin
      state_s     = IDLE;
      out_valid_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            checksum_s = {DATA_W{1'b0}};
            if (first_reg <= last_reg) begin
              last_s  = last_reg;
              idx_s   = first_reg;
              state_s = LOAD;
            end else begin
              state_s = FIN;
            end
          end else begin
            state_s = IDLE;
          end
        end
        LOAD: begin
          load_beat_s = 1'b1;
          state_s     = SEND;
        end
        SEND: begin
          if (fire_s) begin
            checksum_s = checksum_r + out_data_r;
            if (out_last_r) begin
              out_valid_s = 1'b0;
              state_s     = FIN;
            end else begin
              load_beat_s = 1'b1;
            end
          end else begin
            state_s = SEND;
          end
        end
        FIN: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase

      // A beat is captured from the read port; idx stops at last so it never wraps.
      if (load_beat_s) begin
        out_data_s  = rdata;
        out_index_s = idx_r;
        out_last_s  = (idx_r == last_r);
        out_valid_s = 1'b1;
        if (idx_r != last_r) begin
          idx_s = idx_r + ADDR_W'(1);
        end else begin
          idx_s = idx_r;
        end
      end else begin
        out_data_s  = out_data_r;
        out_index_s = out_index_r;
        out_last_s  = out_last_r;
      end
    end

    busy_s = (state_s != IDLE);
    done_s = (state_s == FIN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= {ADDR_W{1'b0}};
      last_r      <= {ADDR_W{1'b0}};
      out_index_r <= {ADDR_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      checksum_r  <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      last_r      <= last_s;
      out_index_r <= out_index_s;
      out_data_r  <= out_data_s;
      out_last_r  <= out_last_s;
      out_valid_r <= out_valid_s;
      checksum_r  <= checksum_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign raddr     = idx_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_index = out_index_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign checksum  = checksum_r;

endmodule
